// File: rtl/bw_pkg.sv
// Shared definitions for the Baugh-Wooley sequential multiplier: legal operand
// widths, FSM state encoding and the signed-mode correction constant.
package bw_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Baugh-Wooley constant 2^n + 2^(2n-1); callers keep the low 2n bits.
  function automatic logic [2*N_MAX-1:0] bw_correction(input int n);
    logic [2*N_MAX-1:0] k;
    k            = '0;
    k[n]         = 1'b1;
    k[2*n-1]     = 1'b1;
    return k;
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One partial-product row a & b_j, with the Baugh-Wooley complements applied
// in signed mode (MSB on ordinary rows, all but the MSB on the last row).
module bw_pp_row #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic         i_b_j,
  input  logic         i_last_row,
  input  logic         i_signed,
  output logic [N-1:0] o_row
);

  logic [N-1:0] w_and;
  logic [N-1:0] w_flip;

  assign w_and = i_a & {N{i_b_j}};

  // Bits to complement: the sign column on ordinary rows, the rest on the last.
  assign w_flip = !i_signed   ? '0 :
                  i_last_row  ? {1'b0, {(N-1){1'b1}}} :
                                {1'b1, {(N-1){1'b0}}};

  assign o_row = w_and ^ w_flip;

endmodule

// File: rtl/bw_seq_multiplier.sv
// Sequential N x N multiplier, one partial-product row per clock, unsigned or
// two's-complement (Baugh-Wooley) per operation, valid/ready on both sides.
module bw_seq_multiplier
  import bw_pkg::*;
#(
  parameter int N              = 4,
  parameter bit SIGNED_DEFAULT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           mode_sel,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] c,
  output logic           busy
);

  if (N < N_MIN || N > N_MAX) begin : g_n_range
    $error("bw_seq_multiplier: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
  end

  localparam int             CW       = $clog2(N);
  localparam logic [CW-1:0]  LAST_ROW = CW'(N - 1);
  localparam logic [2*N-1:0] ACC_INIT = (2*N)'(bw_correction(N));

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_signed;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc;

  logic           w_accept;
  logic           w_b_j;
  logic           w_last_row;
  logic [N-1:0]   w_row;
  logic [2*N-1:0] w_row_shifted;

  assign w_accept      = in_valid & in_ready;
  assign w_b_j         = r_b[r_cnt];
  assign w_last_row    = (r_cnt == LAST_ROW);
  assign w_row_shifted = {{N{1'b0}}, w_row} << r_cnt;

  bw_pp_row #(.N(N)) u_pp_row (
    .i_a        (r_a),
    .i_b_j      (w_b_j),
    .i_last_row (w_last_row),
    .i_signed   (r_signed),
    .o_row      (w_row)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the default is assigned first so no branch leaves w_state_next
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)   w_state_next = ST_CALC;
      ST_CALC: if (abort)      w_state_next = ST_IDLE;
               else if (w_last_row) w_state_next = ST_DONE;
      ST_DONE: if (out_ready)  w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= SIGNED_DEFAULT;
      r_cnt    <= '0;
      r_acc    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= mode_sel;
            r_cnt    <= '0;
            r_acc    <= mode_sel ? ACC_INIT : '0;
          end
        end
        ST_CALC: begin
          // An abort leaves the accumulator stale; it is never exposed on c.
          if (abort) begin
            r_cnt <= '0;
          end else begin
            r_acc <= r_acc + w_row_shifted;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign c         = out_valid ? r_acc : '0;

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Self-checking bench: directed, exhaustive N=4 and random N=8 products
// against an integer-arithmetic reference, plus abort and reset scenarios.
module tb_bw_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid4, in_ready4, mode4, abort4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  c4;

  logic        in_valid8, in_ready8, mode8, abort8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bw_seq_multiplier #(.N(4), .SIGNED_DEFAULT(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .mode_sel(mode4), .abort(abort4), .out_valid(out_valid4),
    .out_ready(out_ready4), .c(c4), .busy(busy4)
  );

  bw_seq_multiplier #(.N(8), .SIGNED_DEFAULT(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .mode_sel(mode8), .abort(abort8), .out_valid(out_valid8),
    .out_ready(out_ready8), .c(c8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Product of two n-bit operands as integers, reduced mod 2^(2n).
  function automatic logic [15:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input int n, input bit sgn);
    longint xv, yv, p;
    xv = longint'(x);
    yv = longint'(y);
    if (sgn && x[n-1]) xv = xv - (longint'(1) << n);
    if (sgn && y[n-1]) yv = yv - (longint'(1) << n);
    p = xv * yv;
    return 16'(p & ((longint'(1) << (2*n)) - 1));
  endfunction

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input bit mode,
                     input logic [7:0] exp_c, input int hold, input bit ab_idle,
                     input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready idle"}, in_ready4, 1'b1);
    in_valid4 = 1'b1; a4 = ta; b4 = tb_v; mode4 = mode; abort4 = ab_idle;
    @(posedge clk);
    @(negedge clk);
    abort4 = 1'b0;
    in_valid4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); mode4 = 1'($urandom);
    check({tag, " busy"}, busy4, 1'b1);
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd4);
    check({tag, " c"}, c4, exp_c);
    check({tag, " in_ready done"}, in_ready4, 1'b0);
    for (int h = 0; h < hold; h++) begin
      abort4 = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold c"}, c4, exp_c);
      check({tag, " hold valid"}, out_valid4, 1'b1);
    end
    abort4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    check({tag, " valid drop"}, out_valid4, 1'b0);
    check({tag, " c zero"}, c4, 8'h00);
    check({tag, " in_ready back"}, in_ready4, 1'b1);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input bit mode,
                     input logic [15:0] exp_c, input int hold, input string tag);
    int lat;
    @(negedge clk);
    in_valid8 = 1'b1; a8 = ta; b8 = tb_v; mode8 = mode;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " c"}, c8, exp_c);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold c"}, c8, exp_c);
      check({tag, " hold valid"}, out_valid8, 1'b1);
      check({tag, " hold in_ready"}, in_ready8, 1'b0);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check({tag, " valid drop"}, out_valid8, 1'b0);
  endtask

  // Starts an N=4 op and advances the given number of edges past accept.
  task automatic start4(input logic [3:0] ta, input logic [3:0] tb_v, input bit mode,
                        input int edges);
    @(negedge clk);
    in_valid4 = 1'b1; a4 = ta; b4 = tb_v; mode4 = mode;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (edges) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb;
    logic [7:0] sa, sb;
    bit         rm;

    rst_n = 1'b0;
    in_valid4 = 0; a4 = 0; b4 = 0; mode4 = 0; abort4 = 0; out_ready4 = 0;
    in_valid8 = 0; a8 = 0; b8 = 0; mode8 = 0; abort8 = 0; out_ready8 = 0;

    #12;
    check("reset out_valid", out_valid4, 1'b0);
    check("reset busy", busy4, 1'b0);
    check("reset c", c4, 8'h00);
    check("reset in_ready", in_ready4, 1'b1);
    check("reset8 in_ready", in_ready8, 1'b1);
    check("reset8 c", c8, 16'h0000);

    // Release mid-high so the next rising edge is the first after deassertion.
    @(posedge clk);
    #2 rst_n = 1'b1;

    op4(4'b1110, 4'b0111, 1'b1, 8'hF2, 2, 1'b0, "dir signed");
    op4(4'b1110, 4'b0111, 1'b0, 8'h62, 0, 1'b0, "dir unsigned");
    op4(4'b1000, 4'b1000, 1'b1, 8'h40, 0, 1'b1, "abort in idle");

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int m = 0; m < 2; m++)
          op4(4'(i), 4'(j), 1'(m), 8'(ref_mul(32'(i), 32'(j), 4, 1'(m))), 0, 1'b0, "exh");

    for (int k = 0; k < 20; k++) begin
      ra = 4'($urandom); rb = 4'($urandom); rm = 1'($urandom);
      op4(ra, rb, rm, 8'(ref_mul(32'(ra), 32'(rb), 4, rm)),
          int'($urandom_range(0, 3)), 1'($urandom), "rand4");
    end

    // Abort on the final-row edge (counter = N-1 after three row edges).
    start4(4'd5, 4'd7, 1'b0, 3);
    abort4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort4 = 1'b0;
    check("abort out_valid", out_valid4, 1'b0);
    check("abort in_ready", in_ready4, 1'b1);
    check("abort busy", busy4, 1'b0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check("abort no late valid", out_valid4, 1'b0);
    end
    op4(4'd5, 4'd7, 1'b0, 8'd35, 0, 1'b0, "after abort");

    // Reset mid-CALC.
    start4(4'd7, 4'd7, 1'b1, 2);
    check("pre reset busy", busy4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst calc busy", busy4, 1'b0);
    check("rst calc in_ready", in_ready4, 1'b1);
    check("rst calc out_valid", out_valid4, 1'b0);
    check("rst calc c", c4, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    op4(4'd3, 4'hE, 1'b1, 8'hFA, 0, 1'b0, "after reset 3x-2");

    // Reset in DONE must clear the held product asynchronously.
    start4(4'd7, 4'd7, 1'b1, 4);
    check("pre reset valid", out_valid4, 1'b1);
    check("pre reset c", c4, 8'h31);
    #2 rst_n = 1'b0;
    #1;
    check("rst done out_valid", out_valid4, 1'b0);
    check("rst done c", c4, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no stale valid", out_valid4, 1'b0);
    end

    op8(8'h80, 8'h80, 1'b1, 16'h4000, 5, "n8 min sq");
    for (int k = 0; k < 20; k++) begin
      sa = 8'($urandom); sb = 8'($urandom); rm = 1'($urandom);
      op8(sa, sb, rm, ref_mul(32'(sa), 32'(sb), 8, rm), 0, "rand8");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
